// File: rtl/mul_seq_unit_if.sv
// rtl/mul_seq_unit_if.sv - execute-stage handshake bundle for the iterative multiply sequencer
//
// Purpose: groups the E-stage request (start/abort/operands) and the unit's
//          response (stall, done pulse, product, flags) into one bundle.
// Ports (signals):
//   StartE      master->slave  qualified MUL/MLA in E
//   AccumulateE master->slave  1 = MLA, 0 = MUL
//   AbortE      master->slave  flush of E, cancels the operation
//   SrcAE/SrcBE/SrcCE master->slave  multiplicand, multiplier, accumulator
//   StallMulE   slave->master  freeze F/D/E (combinational)
//   DoneE       slave->master  one-cycle result-valid pulse
//   ResultE     slave->master  low WIDTH bits of SrcA*SrcB (+SrcC)
//   MulFlagsE   slave->master  {N, Z} of ResultE
interface mul_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic             AccumulateE;
  logic             AbortE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic [WIDTH-1:0] SrcCE;
  logic             StallMulE;
  logic             DoneE;
  logic [WIDTH-1:0] ResultE;
  logic [1:0]       MulFlagsE;

  modport master (
    output StartE, AccumulateE, AbortE, SrcAE, SrcBE, SrcCE,
    input  StallMulE, DoneE, ResultE, MulFlagsE
  );

  modport slave (
    input  StartE, AccumulateE, AbortE, SrcAE, SrcBE, SrcCE,
    output StallMulE, DoneE, ResultE, MulFlagsE
  );
endinterface

// File: rtl/mul_seq_unit.sv
// rtl/mul_seq_unit.sv - radix-2 shift-add MUL/MLA sequencer with early termination
//
// Purpose: on a qualified multiply in E, freezes the pipeline and performs one
//          shift-add step per clock until the remaining multiplier is zero,
//          then pulses DoneE with the registered product and {N, Z} flags.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    mul_seq_unit_if.slave: StartE, AccumulateE, AbortE, SrcAE, SrcBE,
//          SrcCE in; StallMulE, DoneE, ResultE, MulFlagsE out
module mul_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic          clk,
  input  logic          reset,
  mul_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNTW-1:0]  count;
  logic [WIDTH-1:0] resultQ;
  logic [1:0]       flagsQ;
  logic             doneQ;

  logic [WIDTH-1:0] accNext;
  logic             lastStep;
  logic             accept;

  assign accNext  = mplier[0] ? acc + mcand : acc;
  // Stop once no multiplier bits remain after this step, or after the final bit.
  assign lastStep = ((mplier >> 1) == '0) || (count == CNTW'(WIDTH - 1));
  // A new operation may be taken from IDLE or straight out of DONE.
  assign accept   = bus.StartE & ~bus.AbortE & (state != RUN);

  // Abort releases the pipeline in the same cycle it is seen.
  assign bus.StallMulE = ~bus.AbortE & ((state == RUN) | bus.StartE);
  assign bus.DoneE     = doneQ;
  assign bus.ResultE   = resultQ;
  assign bus.MulFlagsE = flagsQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      resultQ <= '0;
      flagsQ  <= 2'b01;
      doneQ   <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mcand  <= bus.SrcAE;
            mplier <= bus.SrcBE;
            acc    <= bus.AccumulateE ? bus.SrcCE : '0;
            count  <= '0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (bus.AbortE) begin
            state <= IDLE;
          end else begin
            acc    <= accNext;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (lastStep) begin
              // Result and flags are captured from the final step's sum so
              // they are already valid during the DONE cycle.
              state   <= DONE;
              resultQ <= accNext;
              flagsQ  <= {accNext[WIDTH-1], accNext == '0};
              doneQ   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
